// File: rtl/gcn_agg_pkg.sv
// Shared types and arithmetic for the COO sparse aggregator.
package gcn_agg_pkg;

  localparam int DP_W = 16;
  localparam logic [DP_W-1:0] ACC_MAX = {DP_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LATCH,
    S_ACC_A,
    S_ACC_B,
    S_STREAM,
    S_DONE
  } agg_state_e;

  // One-bit-wider add; carry-out either clamps to all-ones or is dropped.
  function automatic logic [DP_W-1:0] sat_add(input logic [DP_W-1:0] a,
                                               input logic [DP_W-1:0] b,
                                               input logic saturate);
    logic [DP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (saturate && s[DP_W]) ? ACC_MAX : s[DP_W-1:0];
  endfunction

endpackage

// File: rtl/coo_sparse_aggregator_if.sv
// Memory-fetch, control and result-stream bundle of the aggregator.
interface coo_sparse_aggregator_if #(
  parameter int NODE_BW        = 3,
  parameter int EDGE_BW        = 4,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16
);
  logic                                        start;
  logic [EDGE_BW-1:0]                          num_edges;
  logic                                        coo_rd_en;
  logic [EDGE_BW-1:0]                          coo_address;
  logic [1:0][NODE_BW-1:0]                     coo_in;          // [0]=node0, [1]=node1
  logic                                        fm_wm_rd_en;
  logic [NODE_BW-1:0]                          fm_wm_row_index;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  fm_wm_row_data;
  logic                                        out_valid;
  logic                                        out_ready;
  logic [NODE_BW-1:0]                          out_row_index;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  out_row_data;
  logic                                        busy;
  logic                                        done;
  logic                                        err_bad_node;

  // Environment side: control, memories and downstream consumer.
  modport master (
    output start, num_edges, coo_in, fm_wm_row_data, out_ready,
    input  coo_rd_en, coo_address, fm_wm_rd_en, fm_wm_row_index,
           out_valid, out_row_index, out_row_data, busy, done, err_bad_node
  );

  // Aggregator side.
  modport slave (
    input  start, num_edges, coo_in, fm_wm_row_data, out_ready,
    output coo_rd_en, coo_address, fm_wm_rd_en, fm_wm_row_index,
           out_valid, out_row_index, out_row_data, busy, done, err_bad_node
  );
endinterface

// File: rtl/agg_accum_bank.sv
// NUM_OF_NODES x WEIGHT_COLS accumulator bank: clear, one RMW port, one read port.
module agg_accum_bank
  import gcn_agg_pkg::*;
#(
  parameter int NUM_OF_NODES   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = DP_W,
  parameter int SATURATE       = 1,
  parameter int NODE_BW        = $clog2(NUM_OF_NODES + 1)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       clr,
  input  logic                                       acc_en,
  input  logic [NODE_BW-1:0]                         acc_row,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] acc_data,
  input  logic [NODE_BW-1:0]                         rd_row,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] rd_data
);

  logic [NUM_OF_NODES-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] acc_q;

  // Row-addressed accumulate; clear wins over accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (acc_en) begin
      for (int r = 0; r < NUM_OF_NODES; r++) begin
        if (acc_row == NODE_BW'(r)) begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            acc_q[r][c] <= sat_add(acc_q[r][c], acc_data[c], SATURATE != 0);
          end
        end
      end
    end
  end

  // Streaming read mux; out-of-range rows read as zero.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_OF_NODES; r++) begin
      if (rd_row == NODE_BW'(r)) rd_data = acc_q[r];
    end
  end

endmodule

// File: rtl/coo_sparse_aggregator.sv
// Walks a COO edge list, aggregates FM.WM rows per node, streams ADJ.FM.WM rows.
module coo_sparse_aggregator
  import gcn_agg_pkg::*;
#(
  parameter int NUM_OF_NODES   = 6,
  parameter int MAX_EDGES      = 8,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = DP_W,
  parameter int SYMMETRIC      = 1,
  parameter int SATURATE       = 1,
  parameter int NODE_BW        = $clog2(NUM_OF_NODES + 1),
  parameter int EDGE_BW        = $clog2(MAX_EDGES + 1)
) (
  input logic                   clk,
  input logic                   reset,
  coo_sparse_aggregator_if.slave bus
);

  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;

  agg_state_e         state_q, state_d;
  logic [EDGE_BW-1:0] edge_cnt_q, n_edges_q, edges_clamped;
  logic [NODE_BW-1:0] node0_q, node1_q, stream_idx_q;
  logic [NODE_BW-1:0] in0, in1, acc_row, fm_idx;
  logic               err_q, coo_bad, last_edge, last_row, sym_pass;
  logic               next_edge, bank_clr, acc_en, fm_rd, coo_rd, out_vld;
  row_t               rd_data;

  assign in0       = bus.coo_in[0];
  assign in1       = bus.coo_in[1];
  assign coo_bad   = (in0 == '0) || (in1 == '0) ||
                     (in0 > NODE_BW'(NUM_OF_NODES)) || (in1 > NODE_BW'(NUM_OF_NODES));
  assign edges_clamped = (bus.num_edges > EDGE_BW'(MAX_EDGES)) ? EDGE_BW'(MAX_EDGES)
                                                               : bus.num_edges;
  assign last_edge = (edge_cnt_q + EDGE_BW'(1)) == n_edges_q;
  assign last_row  = stream_idx_q == NODE_BW'(NUM_OF_NODES - 1);
  assign sym_pass  = (SYMMETRIC != 0) && (node0_q != node1_q);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d   = state_q;
    coo_rd    = 1'b0;
    fm_rd     = 1'b0;
    fm_idx    = '0;
    acc_en    = 1'b0;
    acc_row   = '0;
    bank_clr  = 1'b0;
    next_edge = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLEAR;
      S_CLEAR: begin
        bank_clr = 1'b1;
        state_d  = (n_edges_q != '0) ? S_FETCH : S_STREAM;
      end
      S_FETCH: begin
        coo_rd  = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        if (coo_bad) begin
          next_edge = 1'b1;
          state_d   = last_edge ? S_STREAM : S_FETCH;
        end else begin
          fm_rd   = 1'b1;
          fm_idx  = in1 - NODE_BW'(1);
          state_d = S_ACC_A;
        end
      end
      S_ACC_A: begin
        acc_en  = 1'b1;
        acc_row = node0_q - NODE_BW'(1);
        if (sym_pass) begin
          fm_rd   = 1'b1;
          fm_idx  = node0_q - NODE_BW'(1);
          state_d = S_ACC_B;
        end else begin
          next_edge = 1'b1;
          state_d   = last_edge ? S_STREAM : S_FETCH;
        end
      end
      S_ACC_B: begin
        acc_en    = 1'b1;
        acc_row   = node1_q - NODE_BW'(1);
        next_edge = 1'b1;
        state_d   = last_edge ? S_STREAM : S_FETCH;
      end
      S_STREAM: if (bus.out_ready && last_row) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping: edge count, latched edge, stream pointer, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_edges_q    <= '0;
      edge_cnt_q   <= '0;
      node0_q      <= '0;
      node1_q      <= '0;
      stream_idx_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.start) begin
        n_edges_q <= edges_clamped;
        err_q     <= 1'b0;
      end
      if (state_q == S_CLEAR)  edge_cnt_q <= '0;
      else if (next_edge)      edge_cnt_q <= edge_cnt_q + EDGE_BW'(1);
      if (state_q == S_LATCH) begin
        node0_q <= in0;
        node1_q <= in1;
        if (coo_bad) err_q <= 1'b1;
      end
      if (state_q == S_STREAM && bus.out_ready)
        stream_idx_q <= last_row ? '0 : stream_idx_q + NODE_BW'(1);
    end
  end

  agg_accum_bank #(
    .NUM_OF_NODES  (NUM_OF_NODES),
    .WEIGHT_COLS   (WEIGHT_COLS),
    .DOT_PROD_WIDTH(DOT_PROD_WIDTH),
    .SATURATE      (SATURATE),
    .NODE_BW       (NODE_BW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .clr     (bank_clr),
    .acc_en  (acc_en),
    .acc_row (acc_row),
    .acc_data(bus.fm_wm_row_data),
    .rd_row  (stream_idx_q),
    .rd_data (rd_data)
  );

  // Outputs are gated to zero outside their owning state.
  assign out_vld              = (state_q == S_STREAM);
  assign bus.coo_rd_en        = coo_rd;
  assign bus.coo_address      = coo_rd ? edge_cnt_q : '0;
  assign bus.fm_wm_rd_en      = fm_rd;
  assign bus.fm_wm_row_index  = fm_idx;
  assign bus.out_valid        = out_vld;
  assign bus.out_row_index    = out_vld ? stream_idx_q : '0;
  assign bus.out_row_data     = out_vld ? rd_data : '0;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.done             = (state_q == S_DONE);
  assign bus.err_bad_node     = err_q;

endmodule

// File: doc/coo_sparse_aggregator.md
Name: coo_sparse_aggregator

Overview:
- Multi-edge successor to the single-edge COO-to-ADJ·FM·WM product stage.
- Walks a whole COO edge list autonomously under an internal FSM and accumulates the FM·WM row of each neighbour into a per-node accumulator bank.
- Supports symmetric (undirected) or directed edges, with saturating arithmetic.
- Streams the finished ADJ·FM·WM rows to the downstream stage through a valid/ready handshake.
- Sits between the COO memory / FM·WM transform block and the next GCN layer.

Parameters:
- NUM_OF_NODES, 6, number of graph nodes = accumulator rows.
- MAX_EDGES, 8, maximum COO columns (edges) per run.
- WEIGHT_COLS, 3, row width in elements.
- DOT_PROD_WIDTH, 16, element width (unsigned).
- SYMMETRIC, 1, 1 = each edge aggregates in both directions; 0 = directed (dst=node0, src=node1).
- SATURATE, 1, 1 = clamp sums at 2^DOT_PROD_WIDTH-1; 0 = wrap modulo 2^DOT_PROD_WIDTH.
- NODE_BW, $clog2(NUM_OF_NODES+1), node index width (node indices are 1-based).
- EDGE_BW, $clog2(MAX_EDGES+1), edge count / address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a run; sampled in IDLE only.
- num_edges  in  EDGE_BW  edges to process; captured on start; values above MAX_EDGES are clamped to MAX_EDGES.
- coo_rd_en  out  1  COO memory read strobe.
- coo_address  out  EDGE_BW  edge index being fetched.
- coo_in[0:1]  in  NODE_BW each  {node0, node1}, valid one cycle after coo_rd_en.
- fm_wm_rd_en  out  1  FM·WM memory read strobe.
- fm_wm_row_index  out  NODE_BW  0-based source row.
- fm_wm_row_data[0:WEIGHT_COLS-1]  in  DOT_PROD_WIDTH each  valid one cycle after fm_wm_rd_en.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts.
- out_row_index  out  NODE_BW  0-based result row.
- out_row_data[0:WEIGHT_COLS-1]  out  DOT_PROD_WIDTH each  result row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.
- err_bad_node  out  1  sticky; cleared on start.

Behaviour:
- Reset: FSM=IDLE, accumulators=0, all strobes/valid/done/busy/err=0, all address/index/data outputs=0.
- States: IDLE, CLEAR, FETCH, LATCH, ACC_A, ACC_B, STREAM, DONE.
- IDLE --start--> CLEAR.
- CLEAR (1 cycle): zero all accumulators, reset edge counter, clear err. Next state: FETCH if num_edges>0, else STREAM.
- FETCH: coo_rd_en=1, coo_address=edge counter -> LATCH.
- LATCH: capture coo_in.
  - If either node is 0 or >NUM_OF_NODES: set err_bad_node, skip the edge (next edge or STREAM).
  - Else: fm_wm_rd_en=1, fm_wm_row_index=node1-1 -> ACC_A.
- ACC_A: acc[node0-1] += fm_wm_row_data, element-wise.
  - If SYMMETRIC and node0!=node1: fm_wm_rd_en=1, fm_wm_row_index=node0-1 -> ACC_B.
  - Else: next edge.
- ACC_B: acc[node1-1] += fm_wm_row_data, then next edge.
- Self-loop (node0==node1): aggregated exactly once.
- Next edge: increment the counter. If counter==num_edges -> STREAM, else FETCH.
- Edge cost: 4 cycles for a symmetric non-self edge; 3 cycles for a directed edge or self-loop; 2 cycles for a bad edge.
- Arithmetic:
  - Compute with a DOT_PROD_WIDTH+1 bit intermediate.
  - SATURATE=1: clamp to all-ones on carry-out.
  - SATURATE=0: drop the carry.
- STREAM: rows 0..NUM_OF_NODES-1 in order.
  - out_valid=1 with out_row_index and out_row_data held stable until out_valid&&out_ready.
  - After the final handshake -> DONE.
  - out_ready may be high before valid; no combinational path from out_ready to out_valid.
- DONE: done=1 for one cycle -> IDLE. err_bad_node persists until the next start.
- start while busy is ignored.
- Reset mid-run: immediate return to reset state; the partial run is discarded.

Decomposition:
- Package gcn_agg_pkg holds:
  - the state enum type;
  - a function sat_add(a,b,saturate) returning DOT_PROD_WIDTH bits;
  - localparam ACC_MAX = all-ones.
- One natural sub-module: agg_accum_bank, a NUM_OF_NODES x WEIGHT_COLS register bank with clear, one read-modify-write port and one read port for streaming.
- The FSM stays in the top level.

Test Plan:
- Basic accumulation: SYMMETRIC=1, NUM_OF_NODES=6; edges (1,2),(2,3), num_edges=2; FM·WM row r = {r+1,r+1,r+1} for 0-based r.
  - Expect streamed rows: 0:{2,2,2}, 1:{4,4,4}, 2:{2,2,2}, 3..5:{0,0,0}.
  - Expect done one cycle after the row-5 handshake.
- Self-loop: edge (4,4) -> row 3 = {4,4,4}, added once only; total run is 3 edge cycles.
- Bad node: edge (0,3) then (7,1) then (1,1).
  - Expect err_bad_node=1; only row 0 = {1,1,1}; all other rows zero.
- Saturation: SATURATE=1, DOT_PROD_WIDTH=16, source row value 0xFFF0, five edges into the same destination.
  - Expect 0xFFFF.
  - With SATURATE=0, expect the wrapped value 0xFFB0.
- Backpressure and edge cases:
  - Toggle out_ready 1,0,0,1 during STREAM: data and index remain stable while stalled; no row is dropped or duplicated.
  - num_edges=0: CLEAR then STREAM of all-zero rows.
- Reset and start handling:
  - Assert reset during ACC_B: all outputs return to reset values next edge; a new start recomputes from zero.
  - start pulsed while busy is ignored.
